// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the cpu_seq accumulator sequencer:
// opcode values, FSM state encoding and the operand-count decode.
package cpu_seq_pkg;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_LDA  = 8'h02;
  localparam logic [7:0] OP_STA  = 8'h03;
  localparam logic [7:0] OP_OUT  = 8'h04;
  localparam logic [7:0] OP_JMP  = 8'h05;
  localparam logic [7:0] OP_JNZ  = 8'h06;
  localparam logic [7:0] OP_DEC  = 8'h07;
  localparam logic [7:0] OP_NOP  = 8'h08;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_RDWAIT  = 4'd2,
    S_DECODE  = 4'd3,
    S_OPLO    = 4'd4,
    S_OPHI    = 4'd5,
    S_EXEC    = 4'd6,
    S_MEMRD   = 4'd7,
    S_TXWAIT  = 4'd8,
    S_TXGUARD = 4'd9
  } state_t;

  // Operand bytes following an opcode; undefined opcodes take none and trap in EXEC.
  function automatic logic [1:0] op_bytes(input logic [7:0] op);
    logic [1:0] n;
    case (op)
      OP_LDI:                         n = 2'd1;
      OP_LDA, OP_STA, OP_JMP, OP_JNZ: n = 2'd2;
      default:                        n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ram_read_wait.sv
// Wait-state counter for RAM reads: loaded by go, done marks the last
// of the RD_LAT-1 cycles spent in RDWAIT.
module ram_read_wait #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic done
);

  localparam logic [2:0] LOAD = 3'(RD_LAT - 1);

  logic [2:0] cnt_r;

  // Count down the remaining wait cycles of the current read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 3'd0;
    end else if (go) begin
      cnt_r <= LOAD;
    end else if (cnt_r != 3'd0) begin
      cnt_r <= cnt_r - 3'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == 3'd1);

endmodule

// File: rtl/cpu_seq.sv
// Accumulator sequencer CPU: fetches byte opcodes from block RAM, executes
// load/store/branch/decrement and hands bytes to the UART transmitter.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] startaddr,
  input  logic [7:0]        dread,
  output logic [ADDR_W-1:0] c_raddr,
  output logic [ADDR_W-1:0] c_waddr,
  output logic [7:0]        dwrite,
  output logic              write_en,
  output logic [7:0]        tx_byte,
  output logic              transmit,
  input  logic              is_transmitting,
  output logic              halted,
  output logic              illegal,
  output logic              led
);

  // With RD_LAT=1 the issuing state consumes the data on its very next cycle.
  localparam logic              USE_WAIT = (RD_LAT > 1);
  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s, ret_r, ret_s;
  logic              rd_pend_r, rd_pend_s, go_s, rd_done_s;
  logic [ADDR_W-1:0] pc_r, pc_s, raddr_r, raddr_s, waddr_r, waddr_s, op_addr_s;
  logic [7:0]        acc_r, acc_s, opcode_r, opcode_s, lo_r, lo_s, hi_r, hi_s;
  logic [7:0]        dwrite_r, dwrite_s, tx_r, tx_s;
  logic              we_r, we_s, xmit_r, xmit_s, halt_r, halt_s, led_r, led_s, ill_r, ill_s;

  ram_read_wait #(.RD_LAT(RD_LAT)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .go   (go_s),
    .done (rd_done_s)
  );

  assign op_addr_s = ADDR_W'({hi_r, lo_r});

  // Next-state and next-output decode; every register holds unless changed here.
  always_comb begin
    state_s   = state_r;
    ret_s     = ret_r;
    rd_pend_s = rd_pend_r;
    go_s      = 1'b0;
    pc_s      = pc_r;
    acc_s     = acc_r;
    opcode_s  = opcode_r;
    lo_s      = lo_r;
    hi_s      = hi_r;
    raddr_s   = raddr_r;
    waddr_s   = waddr_r;
    dwrite_s  = dwrite_r;
    tx_s      = tx_r;
    ill_s     = ill_r;
    we_s      = 1'b0;
    xmit_s    = 1'b0;
    halt_s    = 1'b0;
    led_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          pc_s    = startaddr;
          ill_s   = 1'b0;
          state_s = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (!rd_pend_r) begin
          raddr_s   = pc_r;
          rd_pend_s = 1'b1;
          go_s      = USE_WAIT;
          ret_s     = S_FETCH;
          state_s   = USE_WAIT ? S_RDWAIT : S_FETCH;
        end else begin
          opcode_s  = dread;
          pc_s      = pc_r + PC_ONE;
          rd_pend_s = 1'b0;
          state_s   = S_DECODE;
        end
      end
      S_RDWAIT: begin
        if (rd_done_s) begin
          state_s = ret_r;
        end else begin
          state_s = S_RDWAIT;
        end
      end
      S_DECODE: begin
        led_s   = 1'b1;
        state_s = (op_bytes(opcode_r) == 2'd0) ? S_EXEC : S_OPLO;
      end
      S_OPLO: begin
        if (!rd_pend_r) begin
          raddr_s   = pc_r;
          rd_pend_s = 1'b1;
          go_s      = USE_WAIT;
          ret_s     = S_OPLO;
          state_s   = USE_WAIT ? S_RDWAIT : S_OPLO;
        end else begin
          lo_s      = dread;
          hi_s      = 8'h00;
          pc_s      = pc_r + PC_ONE;
          rd_pend_s = 1'b0;
          state_s   = (op_bytes(opcode_r) == 2'd2) ? S_OPHI : S_EXEC;
        end
      end
      S_OPHI: begin
        if (!rd_pend_r) begin
          raddr_s   = pc_r;
          rd_pend_s = 1'b1;
          go_s      = USE_WAIT;
          ret_s     = S_OPHI;
          state_s   = USE_WAIT ? S_RDWAIT : S_OPHI;
        end else begin
          hi_s      = dread;
          pc_s      = pc_r + PC_ONE;
          rd_pend_s = 1'b0;
          state_s   = S_EXEC;
        end
      end
      S_EXEC: begin
        state_s = S_FETCH;
        case (opcode_r)
          OP_HALT: begin
            halt_s  = 1'b1;
            state_s = S_IDLE;
          end
          OP_LDI: acc_s = lo_r;
          OP_LDA: state_s = S_MEMRD;
          OP_STA: begin
            waddr_s  = op_addr_s;
            dwrite_s = acc_r;
            we_s     = 1'b1;
          end
          OP_OUT: state_s = S_TXWAIT;
          OP_JMP: pc_s = op_addr_s;
          OP_JNZ: begin
            if (acc_r != 8'h00) begin
              pc_s = op_addr_s;
            end else begin
              pc_s = pc_r;
            end
          end
          OP_DEC: acc_s = acc_r - 8'h01;
          OP_NOP: state_s = S_FETCH;
          default: begin
            ill_s   = 1'b1;
            halt_s  = 1'b1;
            state_s = S_IDLE;
          end
        endcase
      end
      S_MEMRD: begin
        if (!rd_pend_r) begin
          raddr_s   = op_addr_s;
          rd_pend_s = 1'b1;
          go_s      = USE_WAIT;
          ret_s     = S_MEMRD;
          state_s   = USE_WAIT ? S_RDWAIT : S_MEMRD;
        end else begin
          acc_s     = dread;
          rd_pend_s = 1'b0;
          state_s   = S_FETCH;
        end
      end
      S_TXWAIT: begin
        if (!is_transmitting) begin
          tx_s    = acc_r;
          xmit_s  = 1'b1;
          state_s = S_TXGUARD;
        end else begin
          state_s = S_TXWAIT;
        end
      end
      // The UART raises its busy flag a cycle late; give it that cycle.
      S_TXGUARD: state_s = S_FETCH;
      default:   state_s = S_IDLE;
    endcase
  end

  // State and datapath registers; all outputs come straight from here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      ret_r     <= S_IDLE;
      rd_pend_r <= 1'b0;
      pc_r      <= '0;
      acc_r     <= 8'h00;
      opcode_r  <= 8'h00;
      lo_r      <= 8'h00;
      hi_r      <= 8'h00;
      raddr_r   <= '0;
      waddr_r   <= '0;
      dwrite_r  <= 8'h00;
      tx_r      <= 8'h00;
      we_r      <= 1'b0;
      xmit_r    <= 1'b0;
      halt_r    <= 1'b0;
      led_r     <= 1'b0;
      ill_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      ret_r     <= ret_s;
      rd_pend_r <= rd_pend_s;
      pc_r      <= pc_s;
      acc_r     <= acc_s;
      opcode_r  <= opcode_s;
      lo_r      <= lo_s;
      hi_r      <= hi_s;
      raddr_r   <= raddr_s;
      waddr_r   <= waddr_s;
      dwrite_r  <= dwrite_s;
      tx_r      <= tx_s;
      we_r      <= we_s;
      xmit_r    <= xmit_s;
      halt_r    <= halt_s;
      led_r     <= led_s;
      ill_r     <= ill_s;
    end
  end

  assign c_raddr  = raddr_r;
  assign c_waddr  = waddr_r;
  assign dwrite   = dwrite_r;
  assign write_en = we_r;
  assign tx_byte  = tx_r;
  assign transmit = xmit_r;
  assign halted   = halt_r;
  assign illegal  = ill_r;
  assign led      = led_r;

endmodule

// File: tb/tb_cpu_seq.sv
// Bench for cpu_seq: two instances (defaults, and ADDR_W=12/RD_LAT=4) each on a
// RAM model with matching read latency; expected UART bytes are queued per test.
module tb_cpu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_start, a_we, a_xmit, a_busy, a_halted, a_illegal, a_led;
  logic [8:0]  a_startaddr, a_raddr, a_waddr;
  logic [7:0]  a_dread, a_dwrite, a_tx;
  logic        b_start, b_we, b_xmit, b_busy, b_halted, b_illegal, b_led;
  logic [11:0] b_startaddr, b_raddr, b_waddr;
  logic [7:0]  b_dread, b_dwrite, b_tx, b_p0, b_p1;

  logic [7:0] mem_a [0:511];
  logic [7:0] mem_b [0:4095];

  logic [7:0]  prog_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  obs_tx[$];
  int          n_checks = 0, n_pass = 0;
  int          n_tx, n_we, n_halt, n_led;
  bit          timed_out;
  logic [15:0] last_waddr;
  logic [7:0]  last_dwrite, e, o;

  cpu_seq dut_a (
    .clk(clk), .rst(rst), .start(a_start), .startaddr(a_startaddr), .dread(a_dread),
    .c_raddr(a_raddr), .c_waddr(a_waddr), .dwrite(a_dwrite), .write_en(a_we),
    .tx_byte(a_tx), .transmit(a_xmit), .is_transmitting(a_busy),
    .halted(a_halted), .illegal(a_illegal), .led(a_led)
  );

  cpu_seq #(.ADDR_W(12), .RD_LAT(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .startaddr(b_startaddr), .dread(b_dread),
    .c_raddr(b_raddr), .c_waddr(b_waddr), .dwrite(b_dwrite), .write_en(b_we),
    .tx_byte(b_tx), .transmit(b_xmit), .is_transmitting(b_busy),
    .halted(b_halted), .illegal(b_illegal), .led(b_led)
  );

  always #5 clk = ~clk;

  // RAM A: two-cycle read latency, write on strobe.
  always @(posedge clk) begin
    a_dread <= mem_a[a_raddr];
    if (a_we) mem_a[a_waddr] <= a_dwrite;
  end

  // RAM B: four-cycle read latency, write on strobe.
  always @(posedge clk) begin
    b_p0    <= mem_b[b_raddr];
    b_p1    <= b_p0;
    b_dread <= b_p1;
    if (b_we) mem_b[b_waddr] <= b_dwrite;
  end

  task automatic load(input bit use_b, input int base);
    for (int i = 0; i < 4096; i++) begin
      if (use_b) mem_b[12'(i)] <= 8'h00;
      else if (i < 512) mem_a[9'(i)] <= 8'h00;
    end
    foreach (prog_q[i]) begin
      if (use_b) mem_b[12'(base + i)] <= prog_q[i];
      else mem_a[9'(base + i)] <= prog_q[i];
    end
    @(negedge clk);
  endtask

  task automatic do_start(input bit use_b, input logic [15:0] addr);
    @(negedge clk);
    if (use_b) begin b_start = 1'b1; b_startaddr = addr[11:0]; end
    else begin a_start = 1'b1; a_startaddr = addr[8:0]; end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Capture DUT activity until HALT (plus a few cycles) or the budget runs out.
  task automatic run(input bit use_b, input int budget);
    int limit;
    limit = budget;
    obs_tx.delete();
    n_tx = 0; n_we = 0; n_halt = 0; n_led = 0; timed_out = 1'b1;
    last_waddr = 16'h0000; last_dwrite = 8'h00;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (use_b ? b_xmit : a_xmit) begin
        n_tx++;
        obs_tx.push_back(use_b ? b_tx : a_tx);
      end
      if (use_b ? b_we : a_we) begin
        n_we++;
        last_waddr  = use_b ? 16'(b_waddr) : 16'(a_waddr);
        last_dwrite = use_b ? b_dwrite : a_dwrite;
      end
      if (use_b ? b_led : a_led) n_led++;
      if (use_b ? b_halted : a_halted) begin
        n_halt++;
        if (timed_out) begin timed_out = 1'b0; limit = i + 5; end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    n_checks++; if (a_raddr !== 9'h000) $display("FAIL reset_raddr: got %h want 000", a_raddr); else n_pass++;
    n_checks++; if ({a_waddr, a_dwrite, a_tx} !== 25'h0) $display("FAIL reset_data: got %h/%h/%h want 0", a_waddr, a_dwrite, a_tx); else n_pass++;
    n_checks++; if ({a_we, a_xmit, a_halted, a_illegal, a_led} !== 5'b0) $display("FAIL reset_strobes: got %b want 00000", {a_we, a_xmit, a_halted, a_illegal, a_led}); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ldi_out;
    prog_q = '{8'h01, 8'h41, 8'h04, 8'h00};
    load(1'b0, 0);
    exp_tx.push_back(8'h41);
    do_start(1'b0, 16'h0000);
    run(1'b0, 300);
    n_checks++; if (timed_out) $display("FAIL ldi_timeout: got no halt want halt"); else n_pass++;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); n_checks++;
      if (obs_tx.size() == 0) $display("FAIL ldi_tx: got none want %h", e);
      else begin o = obs_tx.pop_front(); if (o !== e) $display("FAIL ldi_tx: got %h want %h", o, e); else n_pass++; end
    end
    n_checks++; if (n_tx != 1) $display("FAIL ldi_tx_count: got %0d want 1", n_tx); else n_pass++;
    n_checks++; if (n_halt != 1) $display("FAIL ldi_halt_count: got %0d want 1", n_halt); else n_pass++;
    n_checks++; if (n_led != 3) $display("FAIL ldi_led_count: got %0d want 3", n_led); else n_pass++;
    n_checks++; if (a_illegal !== 1'b0) $display("FAIL ldi_illegal: got %b want 0", a_illegal); else n_pass++;
  endtask

  task automatic test_countdown;
    prog_q = '{8'h01, 8'h03, 8'h04, 8'h07, 8'h06, 8'h02, 8'h00, 8'h00};
    load(1'b0, 0);
    exp_tx.push_back(8'h03); exp_tx.push_back(8'h02); exp_tx.push_back(8'h01);
    do_start(1'b0, 16'h0000);
    run(1'b0, 600);
    n_checks++; if (timed_out) $display("FAIL cd_timeout: got no halt want halt"); else n_pass++;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); n_checks++;
      if (obs_tx.size() == 0) $display("FAIL cd_tx: got none want %h", e);
      else begin o = obs_tx.pop_front(); if (o !== e) $display("FAIL cd_tx: got %h want %h", o, e); else n_pass++; end
    end
    n_checks++; if (n_tx != 3) $display("FAIL cd_tx_count: got %0d want 3", n_tx); else n_pass++;
    n_checks++; if (n_halt != 1) $display("FAIL cd_halt_count: got %0d want 1", n_halt); else n_pass++;
  endtask

  task automatic test_store_load;
    prog_q = '{8'h01, 8'h5A, 8'h03, 8'hF0, 8'h01, 8'h01, 8'h00, 8'h02, 8'hF0, 8'h01, 8'h04, 8'h00};
    load(1'b0, 0);
    exp_tx.push_back(8'h5A);
    do_start(1'b0, 16'h0000);
    run(1'b0, 400);
    n_checks++; if (n_we != 1) $display("FAIL st_we_count: got %0d want 1", n_we); else n_pass++;
    n_checks++; if (last_waddr !== 16'h01F0) $display("FAIL st_waddr: got %h want 01f0", last_waddr); else n_pass++;
    n_checks++; if (last_dwrite !== 8'h5A) $display("FAIL st_dwrite: got %h want 5a", last_dwrite); else n_pass++;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); n_checks++;
      if (obs_tx.size() == 0) $display("FAIL ld_tx: got none want %h", e);
      else begin o = obs_tx.pop_front(); if (o !== e) $display("FAIL ld_tx: got %h want %h", o, e); else n_pass++; end
    end
    n_checks++; if (n_halt != 1) $display("FAIL st_halt_count: got %0d want 1", n_halt); else n_pass++;
  endtask

  task automatic test_backpressure;
    int early;
    prog_q = '{8'h01, 8'h41, 8'h04, 8'h00};
    load(1'b0, 0);
    a_busy = 1'b1;
    do_start(1'b0, 16'h0000);
    early = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_xmit) early++;
    end
    a_busy = 1'b0;
    @(negedge clk);
    n_checks++; if (early != 0) $display("FAIL bp_early: got %0d pulses want 0", early); else n_pass++;
    n_checks++; if (a_xmit !== 1'b1) $display("FAIL bp_release: got %b want 1", a_xmit); else n_pass++;
    n_checks++; if (a_tx !== 8'h41) $display("FAIL bp_tx: got %h want 41", a_tx); else n_pass++;
    run(1'b0, 200);
    n_checks++; if (n_tx != 0) $display("FAIL bp_extra_pulses: got %0d want 0", n_tx); else n_pass++;
    n_checks++; if (n_halt != 1) $display("FAIL bp_halt_count: got %0d want 1", n_halt); else n_pass++;
  endtask

  task automatic test_illegal;
    prog_q = '{8'hFF};
    load(1'b0, 16);
    do_start(1'b0, 16'h0010);
    run(1'b0, 200);
    n_checks++; if (a_illegal !== 1'b1) $display("FAIL ill_flag: got %b want 1", a_illegal); else n_pass++;
    n_checks++; if (n_halt != 1) $display("FAIL ill_halt_count: got %0d want 1", n_halt); else n_pass++;
    n_checks++; if (n_tx != 0) $display("FAIL ill_tx_count: got %0d want 0", n_tx); else n_pass++;
    prog_q = '{8'h01, 8'h41, 8'h04, 8'h00};
    load(1'b0, 0);
    exp_tx.push_back(8'h41);
    do_start(1'b0, 16'h0000);
    n_checks++; if (a_illegal !== 1'b0) $display("FAIL ill_clear: got %b want 0", a_illegal); else n_pass++;
    run(1'b0, 300);
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); n_checks++;
      if (obs_tx.size() == 0) $display("FAIL ill_rerun_tx: got none want %h", e);
      else begin o = obs_tx.pop_front(); if (o !== e) $display("FAIL ill_rerun_tx: got %h want %h", o, e); else n_pass++; end
    end
  endtask

  task automatic test_mid_reset;
    bit found;
    prog_q = '{8'h01, 8'h41, 8'h03, 8'h34, 8'h02, 8'h04, 8'h00};
    load(1'b1, 256);
    b_busy = 1'b1;
    do_start(1'b1, 16'h0100);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (b_we) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL mr_write_seen: got none want write"); else n_pass++;
    repeat (12) @(negedge clk);
    n_checks++; if (b_waddr !== 12'h234) $display("FAIL mr_pre_waddr: got %h want 234", b_waddr); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({b_raddr, b_waddr} !== 24'h0) $display("FAIL mr_addr: got %h/%h want 0", b_raddr, b_waddr); else n_pass++;
    n_checks++; if ({b_dwrite, b_tx} !== 16'h0) $display("FAIL mr_data: got %h/%h want 0", b_dwrite, b_tx); else n_pass++;
    n_checks++; if ({b_we, b_xmit, b_halted, b_illegal, b_led} !== 5'b0) $display("FAIL mr_strobes: got %b want 00000", {b_we, b_xmit, b_halted, b_illegal, b_led}); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    b_busy = 1'b0;
  endtask

  task automatic test_wrap_regression;
    prog_q = '{8'h01, 8'h03, 8'h04, 8'h07, 8'h06, 8'hFE, 8'h0F, 8'h00};
    load(1'b1, 12'hFFC);
    exp_tx.push_back(8'h03); exp_tx.push_back(8'h02); exp_tx.push_back(8'h01);
    do_start(1'b1, 16'h0FFC);
    run(1'b1, 1200);
    n_checks++; if (timed_out) $display("FAIL wrap_timeout: got no halt want halt"); else n_pass++;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front(); n_checks++;
      if (obs_tx.size() == 0) $display("FAIL wrap_tx: got none want %h", e);
      else begin o = obs_tx.pop_front(); if (o !== e) $display("FAIL wrap_tx: got %h want %h", o, e); else n_pass++; end
    end
    n_checks++; if (n_tx != 3) $display("FAIL wrap_tx_count: got %0d want 3", n_tx); else n_pass++;
    n_checks++; if (b_raddr !== 12'h003) $display("FAIL wrap_last_fetch: got %h want 003", b_raddr); else n_pass++;
    n_checks++; if (b_illegal !== 1'b0) $display("FAIL wrap_illegal: got %b want 0", b_illegal); else n_pass++;
  endtask

  initial begin
    a_start = 1'b0; a_startaddr = 9'h000; a_busy = 1'b0;
    b_start = 1'b0; b_startaddr = 12'h000; b_busy = 1'b0;
    #3;
    test_reset();
    test_ldi_out();
    test_countdown();
    test_store_load();
    test_backpressure();
    test_illegal();
    test_mid_reset();
    test_wrap_regression();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
